// File: rtl/spy_delay_monitor.sv
// spy_delay_monitor
// -----------------
// Measures the propagation delay of a monitored combinational path. Each trial
// holds the path input low for SETTLE cycles, then launches a rising edge and
// counts clock cycles until the synchronized path output differs from the
// value it had just before the launch. 2^TRIALS_LOG2 trial counts are summed.
// The truncated average is compared with a golden delay. A deviation beyond
// TOL raises trojan_flag.
//
// Ports
//   clk          in   single clock
//   rst          in   asynchronous, active-high reset
//   start        in   one-cycle pulse that begins a run (accepted only in IDLE)
//   golden       in   expected average delay in cycles, latched at start
//   path_out     in   monitored path output (asynchronous, synchronized here)
//   launch       out  registered drive of the monitored path input
//   busy         out  high while a run is in progress
//   done         out  one-cycle pulse at run end
//   trojan_flag  out  average deviates from golden by more than TOL
//   timeout_err  out  a trial saw no response within TIMEOUT cycles
//   delay_avg    out  last average delay
module spy_delay_monitor #(
    parameter int CNT_W       = 8,
    parameter int TRIALS_LOG2 = 2,
    parameter int SETTLE      = 16,
    parameter int TIMEOUT     = 200,
    parameter int TOL         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] golden,
    input  logic             path_out,
    output logic             launch,
    output logic             busy,
    output logic             done,
    output logic             trojan_flag,
    output logic             timeout_err,
    output logic [CNT_W-1:0] delay_avg
);

    localparam int ACC_W  = CNT_W + TRIALS_LOG2;
    localparam int TIDX_W = (TRIALS_LOG2 > 0) ? TRIALS_LOG2 : 1;
    localparam int SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE - 1);
    localparam logic [SET_W-1:0]  SET_ONE     = SET_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  TOL_C       = CNT_W'(TOL);
    localparam logic [TIDX_W-1:0] TIDX_ONE    = TIDX_W'(1'b1);
    localparam logic [TIDX_W-1:0] LAST_TRIAL  = TIDX_W'((1 << TRIALS_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREP    = 2'd1,
        S_MEASURE = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_baseline;
    logic [SET_W-1:0]    r_prep_cnt;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [TIDX_W-1:0]   r_trial;
    logic [CNT_W-1:0]    r_golden;
    logic                r_launch;
    logic                r_busy;
    logic                r_done;
    logic                r_trojan;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_avg;

    logic                w_hit;
    logic                w_settled;
    logic                w_last_trial;
    logic                w_timeout;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [CNT_W-1:0]    w_avg;
    logic [CNT_W-1:0]    w_diff;
    logic                w_flag;

    // Detection compares against the pre-launch level, so inverting paths work too.
    assign w_hit        = (r_sync2 != r_baseline);
    assign w_settled    = (r_prep_cnt == LAST_SETTLE);
    assign w_last_trial = (r_trial == LAST_TRIAL);
    assign w_timeout    = !w_hit && (r_cnt == TIMEOUT_C);
    // The sum includes the count being recorded this cycle, so the final
    // average can be registered on the same edge that leaves MEASURE.
    assign w_acc_sum    = r_acc + ACC_W'(r_cnt);
    assign w_avg        = CNT_W'(w_acc_sum >> TRIALS_LOG2);
    assign w_diff       = (w_avg > r_golden) ? (w_avg - r_golden) : (r_golden - w_avg);
    assign w_flag       = (w_diff > TOL_C);

    assign launch      = r_launch;
    assign busy        = r_busy;
    assign done        = r_done;
    assign trojan_flag = r_trojan;
    assign timeout_err = r_timeout;
    assign delay_avg   = r_avg;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_PREP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PREP: begin
                if (w_settled) begin
                    w_next = S_MEASURE;
                end else begin
                    w_next = S_PREP;
                end
            end
            S_MEASURE: begin
                if (w_hit) begin
                    if (w_last_trial) begin
                        w_next = S_FINISH;
                    end else begin
                        w_next = S_PREP;
                    end
                end else if (w_timeout) begin
                    w_next = S_FINISH;
                end else begin
                    w_next = S_MEASURE;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Synchronizer, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_baseline <= 1'b0;
            r_prep_cnt <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_trial    <= '0;
            r_golden   <= '0;
            r_launch   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_trojan   <= 1'b0;
            r_timeout  <= 1'b0;
            r_avg      <= '0;
        end else begin
            r_sync1  <= path_out;
            r_sync2  <= r_sync1;
            // Outputs are decoded from the next state so they line up with it.
            r_launch <= (w_next == S_MEASURE);
            r_busy   <= (w_next == S_PREP) || (w_next == S_MEASURE);
            r_done   <= (w_next == S_FINISH);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_golden   <= golden;
                        r_acc      <= '0;
                        r_trial    <= '0;
                        r_prep_cnt <= '0;
                        r_trojan   <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_avg      <= '0;
                    end
                end
                S_PREP: begin
                    if (w_settled) begin
                        r_baseline <= r_sync2;
                        r_cnt      <= '0;
                    end else begin
                        r_prep_cnt <= r_prep_cnt + SET_ONE;
                    end
                end
                S_MEASURE: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (w_hit) begin
                        r_acc      <= w_acc_sum;
                        r_prep_cnt <= '0;
                        if (w_last_trial) begin
                            r_avg    <= w_avg;
                            r_trojan <= w_flag;
                        end else begin
                            r_trial <= r_trial + TIDX_ONE;
                        end
                    end else if (w_timeout) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
